// File: rtl/fetch_sequencer_pkg.sv
// Shared types and field/flag constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   localparam int OPCODE_WIDTH  = 5;
   localparam int OPCODE_MSB    = 15;
   localparam int OPCODE_LSB    = 11;
   localparam int OPERAND_WIDTH = 11;
   localparam int OPERAND_MSB   = 10;
   localparam int OPERAND_LSB   = 0;
   localparam int FLAGS_WIDTH   = 3;

   localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 5'h1F;

   localparam int FLAG_Z = 2;
   localparam int FLAG_L = 1;
   localparam int FLAG_G = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the sequencer and imem.
interface fetch_sequencer_if #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
) ();

   logic                   imem_req;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );

endinterface

// File: rtl/fetch_sequencer_branch_resolver.sv
// Combinational branch decision and next-PC computation from registered flags.
module branch_resolver
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_WIDTH = 8
) (
   input  logic                   is_jump,
   input  logic                   is_jz,
   input  logic                   is_jnz,
   input  logic                   is_jl,
   input  logic                   is_jg,
   input  logic [FLAGS_WIDTH-1:0] flags,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic [PC_WIDTH-1:0]    target,
   output logic                   taken,
   output logic [PC_WIDTH-1:0]    next_pc
);

   assign taken = is_jump
                | (is_jz  &  flags[FLAG_Z])
                | (is_jnz & ~flags[FLAG_Z])
                | (is_jl  &  flags[FLAG_L])
                | (is_jg  &  flags[FLAG_G]);

   // Increment wraps naturally at PC_WIDTH bits.
   assign next_pc = taken ? target : pc + PC_WIDTH'(1);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR and the flags register.
//
// state      | meaning
// ST_IDLE    | waiting for run
// ST_FETCH   | imem_req high at addr=pc until imem_valid
// ST_DECODE  | IR loaded, control unit settles; halt opcode detected here
// ST_EXECUTE | exec_en strobe; pc and flags commit at the closing edge
// ST_HALT    | halt opcode reached; only reset leaves
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                      PC_WIDTH    = 8,
   parameter int                      INSTR_WIDTH = 16,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     run,
   fetch_sequencer_if.master        imem,
   output logic [OPCODE_WIDTH-1:0]  opcode,
   output logic [OPERAND_WIDTH-1:0] operand,
   input  logic                     is_jump,
   input  logic                     is_jz,
   input  logic                     is_jnz,
   input  logic                     is_jl,
   input  logic                     is_jg,
   input  logic                     flags_write,
   input  logic [FLAGS_WIDTH-1:0]   alu_flags,
   output logic                     exec_en,
   output logic [FLAGS_WIDTH-1:0]   flags,
   output logic [PC_WIDTH-1:0]      pc,
   output logic                     halted
);

   state_t                 state;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   taken;
   logic [PC_WIDTH-1:0]    next_pc;

   assign opcode         = ir[OPCODE_MSB:OPCODE_LSB];
   assign operand        = ir[OPERAND_MSB:OPERAND_LSB];
   assign imem.imem_addr = pc;

   branch_resolver #(.PC_WIDTH(PC_WIDTH)) u_branch_resolver (
      .is_jump (is_jump),
      .is_jz   (is_jz),
      .is_jnz  (is_jnz),
      .is_jl   (is_jl),
      .is_jg   (is_jg),
      .flags   (flags),
      .pc      (pc),
      .target  (operand[PC_WIDTH-1:0]),
      .taken   (taken),
      .next_pc (next_pc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         pc            <= '0;
         ir            <= '0;
         flags         <= '0;
         imem.imem_req <= 1'b0;
         exec_en       <= 1'b0;
         halted        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state         <= ST_FETCH;
                  imem.imem_req <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem.imem_valid) begin
                  ir            <= imem.imem_rdata;
                  imem.imem_req <= 1'b0;
                  state         <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (opcode == HALT_OPCODE) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end else begin
                  state   <= ST_EXECUTE;
                  exec_en <= 1'b1;
               end
            end
            ST_EXECUTE: begin
               // Branch decision uses flags before this instruction's own write.
               exec_en       <= 1'b0;
               pc            <= next_pc;
               if (flags_write) flags <= alu_flags;
               imem.imem_req <= run;
               state         <= run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle compare against an instruction-level model.
module tb_fetch_sequencer;

   localparam logic [4:0] BR_NONE = 5'b00000;
   localparam logic [4:0] BR_JUMP = 5'b10000;
   localparam logic [4:0] BR_JZ   = 5'b01000;
   localparam logic [4:0] BR_JNZ  = 5'b00100;
   localparam logic [4:0] BR_JL   = 5'b00010;
   localparam logic [4:0] BR_JG   = 5'b00001;

   logic        clk;
   logic        reset_n;
   logic        run;
   logic [4:0]  opcode;
   logic [10:0] operand;
   logic        is_jump, is_jz, is_jnz, is_jl, is_jg;
   logic        flags_write;
   logic [2:0]  alu_flags;
   logic        exec_en;
   logic [2:0]  flags;
   logic [7:0]  pc;
   logic        halted;

   fetch_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem_bus ();

   fetch_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .imem        (imem_bus),
      .opcode      (opcode),
      .operand     (operand),
      .is_jump     (is_jump),
      .is_jz       (is_jz),
      .is_jnz      (is_jnz),
      .is_jl       (is_jl),
      .is_jg       (is_jg),
      .flags_write (flags_write),
      .alu_flags   (alu_flags),
      .exec_en     (exec_en),
      .flags       (flags),
      .pc          (pc),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model of what the outputs must show during the current cycle.
   bit          chk_en = 1'b0;
   logic        exp_req;
   logic        exp_exec;
   logic [7:0]  exp_pc;
   logic [2:0]  exp_flags;
   logic        exp_halted;
   logic [4:0]  exp_opcode;
   logic [10:0] exp_operand;

   task automatic cmp(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("imem_req", int'(imem_bus.imem_req), int'(exp_req));
         if (exp_req) cmp("imem_addr", int'(imem_bus.imem_addr), int'(exp_pc));
         cmp("exec_en", int'(exec_en), int'(exp_exec));
         cmp("pc", int'(pc), int'(exp_pc));
         cmp("flags", int'(flags), int'(exp_flags));
         cmp("halted", int'(halted), int'(exp_halted));
         cmp("opcode", int'(opcode), int'(exp_opcode));
         cmp("operand", int'(operand), int'(exp_operand));
      end
   end

   function automatic bit model_taken(input logic [4:0] br, input logic [2:0] f);
      bit z, l, g;
      z = f[2]; l = f[1]; g = f[0];
      return br[4] || (br[3] && z) || (br[2] && !z) || (br[1] && l) || (br[0] && g);
   endfunction

   task automatic model_reset();
      exp_req = 0; exp_exec = 0; exp_pc = 8'h00; exp_flags = 3'b000;
      exp_halted = 0; exp_opcode = 5'h00; exp_operand = 11'h000;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Values that must be ignored outside EXECUTE / outside an open request.
   task automatic drive_junk();
      {is_jump, is_jz, is_jnz, is_jl, is_jg} = 5'b11111;
      flags_write = 1'b1;
      alu_flags   = 3'b111;
   endtask

   task automatic start_run();
      run = 1'b1;
      step();
      exp_req = 1'b1;
   endtask

   // Called at the start of a FETCH cycle; leaves the bench at the start of the next state.
   task automatic exec_instr(input logic [15:0] instr, input int waits, input logic [4:0] br,
                             input logic fw, input logic [2:0] af, input logic run_next,
                             input bit rst_in_exec);
      logic [7:0] npc;
      run = run_next;
      drive_junk();
      for (int i = 0; i < waits; i++) begin
         imem_bus.imem_valid = 1'b0;
         imem_bus.imem_rdata = 16'hFFFF;
         step();
      end
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = instr;
      step();
      exp_req     = 1'b0;
      exp_opcode  = instr[15:11];
      exp_operand = instr[10:0];
      imem_bus.imem_rdata = 16'hA5A5;
      step();
      if (instr[15:11] == 5'h1F) begin
         exp_halted = 1'b1;
         return;
      end
      exp_exec = 1'b1;
      {is_jump, is_jz, is_jnz, is_jl, is_jg} = br;
      flags_write = fw;
      alu_flags   = af;
      if (rst_in_exec) reset_n = 1'b0;
      npc = model_taken(br, exp_flags) ? instr[7:0] : exp_pc + 8'd1;
      step();
      if (rst_in_exec) begin
         reset_n = 1'b1;
         model_reset();
         return;
      end
      exp_exec = 1'b0;
      exp_pc   = npc;
      if (fw) exp_flags = af;
      exp_req  = run_next;
      drive_junk();
   endtask

   initial begin
      reset_n = 1'b0;
      run = 1'b0;
      imem_bus.imem_valid = 1'b0;
      imem_bus.imem_rdata = 16'h0000;
      {is_jump, is_jz, is_jnz, is_jl, is_jg} = BR_NONE;
      flags_write = 1'b0;
      alu_flags = 3'b000;
      model_reset();
      step();
      step();
      reset_n = 1'b1;
      chk_en = 1'b1;
      cmp("reset_pc_lit", int'(pc), 0);
      cmp("reset_flags_lit", int'(flags), 0);
      step();

      // Zero-wait sequential run.
      start_run();
      exec_instr(16'h0800, 0, BR_NONE, 1'b0, 3'b000, 1'b1, 0);
      exec_instr(16'h0801, 0, BR_NONE, 1'b0, 3'b000, 1'b1, 0);
      exec_instr(16'h0802, 0, BR_NONE, 1'b0, 3'b000, 1'b1, 0);
      cmp("seq_pc_lit", int'(pc), 3);

      // Four wait states.
      exec_instr(16'h1123, 4, BR_NONE, 1'b0, 3'b000, 1'b1, 0);
      cmp("wait_pc_lit", int'(pc), 4);

      // Flag ordering: jz sees old flags, flags update same edge.
      exec_instr(16'h1040, 0, BR_JZ, 1'b1, 3'b100, 1'b1, 0);
      cmp("order_pc_lit", int'(pc), 5);
      cmp("order_flags_lit", int'(flags), 4);
      cmp("order_model_lit", int'(exp_pc), 5);
      exec_instr(16'h1040, 0, BR_JZ, 1'b0, 3'b000, 1'b1, 0);
      cmp("jz_taken_pc_lit", int'(pc), 8'h40);
      exec_instr(16'h1033, 1, BR_JNZ, 1'b0, 3'b000, 1'b1, 0);
      cmp("jnz_not_taken_pc_lit", int'(pc), 8'h41);
      exec_instr(16'h1FFF, 0, BR_JUMP, 1'b0, 3'b000, 1'b1, 0);
      cmp("jump_trunc_pc_lit", int'(pc), 8'hFF);
      exec_instr(16'h0800, 0, BR_NONE, 1'b0, 3'b000, 1'b1, 0);
      cmp("wrap_pc_lit", int'(pc), 8'h00);

      // jg against old flags (Z only), then combined jl|jg taken on G.
      exec_instr(16'h1050, 0, BR_JG, 1'b1, 3'b001, 1'b1, 0);
      cmp("jg_old_flags_pc_lit", int'(pc), 1);
      exec_instr(16'h1012, 2, BR_JL | BR_JG, 1'b0, 3'b000, 1'b1, 0);
      cmp("multi_br_pc_lit", int'(pc), 8'h12);

      // Reset during EXECUTE at pc=0x12: no commit.
      exec_instr(16'h1077, 0, BR_JUMP, 1'b1, 3'b111, 1'b0, 1);
      cmp("rst_exec_pc_lit", int'(pc), 0);
      cmp("rst_exec_flags_lit", int'(flags), 0);
      step();
      step();

      // run dropped during FETCH: instruction completes, then IDLE.
      start_run();
      exec_instr(16'h0900, 2, BR_NONE, 1'b0, 3'b000, 1'b0, 0);
      step();
      step();
      step();
      cmp("idle_pc_lit", int'(pc), 1);

      // Halt opcode freezes the sequencer until reset.
      start_run();
      exec_instr(16'hF800, 1, BR_NONE, 1'b0, 3'b000, 1'b1, 0);
      imem_bus.imem_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      cmp("halt_halted_lit", int'(halted), 1);
      cmp("halt_pc_lit", int'(pc), 1);
      reset_n = 1'b0;
      run = 1'b0;
      step();
      reset_n = 1'b1;
      model_reset();
      step();
      cmp("halt_cleared_lit", int'(halted), 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
